// File: rtl/aes_mixcol_engine.sv
// AES MixColumns / InvMixColumns engine over a four-column state.
// COLS_PER_CYCLE column units walk the working register in place.
module aes_mixcol_engine #(
    parameter int COLS_PER_CYCLE = 4,
    parameter bit INV_EN         = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_in,
    input  logic        inv_in,
    input  logic [31:0] state_in0,
    input  logic [31:0] state_in1,
    input  logic [31:0] state_in2,
    input  logic [31:0] state_in3,
    output logic [31:0] state_out0,
    output logic [31:0] state_out1,
    output logic [31:0] state_out2,
    output logic [31:0] state_out3,
    output logic        done,
    output logic        busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
          COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic {IDLE, RUN} fsm_t;

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    fsm_t        fsm;
    logic [1:0]  cnt;
    logic        inv_q;
    logic [31:0] work [4];
    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_new [COLS_PER_CYCLE];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One output byte: p is the same-row byte, q/s/t the next rows.
    function automatic logic [7:0] row(input logic [7:0] p,
                                       input logic [7:0] q,
                                       input logic [7:0] s,
                                       input logic [7:0] t,
                                       input logic       inv);
        logic [7:0] p2, p4, p8, q2, q4, q8, s2, s4, s8, t2, t4, t8;
        p2 = xt(p);
        p4 = xt(p2);
        p8 = xt(p4);
        q2 = xt(q);
        q4 = xt(q2);
        q8 = xt(q4);
        s2 = xt(s);
        s4 = xt(s2);
        s8 = xt(s4);
        t2 = xt(t);
        t4 = xt(t2);
        t8 = xt(t4);
        if (INV_EN && inv)
            return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^
                   (s8 ^ s4 ^ s) ^ (t8 ^ t);
        else
            return p2 ^ q2 ^ q ^ s ^ t;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] c,
                                        input logic        inv);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        return {row(a3, a0, a1, a2, inv), row(a2, a3, a0, a1, inv),
                row(a1, a2, a3, a0, inv), row(a0, a1, a2, a3, inv)};
    endfunction

    for (genvar u = 0; u < COLS_PER_CYCLE; u++) begin : g_unit
        assign col_idx[u] = cnt + 2'(u);
        assign col_new[u] = mix(work[col_idx[u]], inv_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm   <= IDLE;
            cnt   <= 2'd0;
            inv_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < 4; i++) work[i] <= 32'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    done <= 1'b0;
                    if (start_in) begin
                        work[0] <= state_in0;
                        work[1] <= state_in1;
                        work[2] <= state_in2;
                        work[3] <= state_in3;
                        inv_q   <= INV_EN ? inv_in : 1'b0;
                        cnt     <= 2'd0;
                        busy    <= 1'b1;
                        fsm     <= RUN;
                    end
                end
                RUN: begin
                    for (int u = 0; u < COLS_PER_CYCLE; u++)
                        work[col_idx[u]] <= col_new[u];
                    cnt <= cnt + STEP;
                    if (cnt == LAST) begin
                        fsm  <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign state_out0 = work[0];
    assign state_out1 = work[1];
    assign state_out2 = work[2];
    assign state_out3 = work[3];

endmodule
